freq_meter: RTL and testbench
=============================

# freq_meter

Gated frequency counter that measures an asynchronous slow signal against the system clock, such as a divided clock, a blink/strobe output or an external pin. It is the measuring counterpart to the clock-divider blocks: it synchronises the input and counts its rising edges over a fixed gate of `GATE_CYCLES` system clocks. At the end of each gate it publishes the count with a one-cycle `valid` strobe. Its consumers are display/debug logic and self-test of the divider chain.

## Interface
- `GATE_CYCLES`, 50_000_000. Gate length in `clk` cycles (≥ 2); at 50 MHz this gives a 1 s gate, so `count` reads directly in Hz.
- `CNT_WIDTH`, 32. Width of `count` (and `period`).
- `SYNC_STAGES`, 2. Synchroniser flops on `sig_in` (≥ 2).
- `clk` input 1. System clock; all logic is on its rising edge.
- `rst_n` input 1. Reset, synchronous and active-low.
- `sig_in` input 1. Measured signal, asynchronous to `clk`.
- `en` input 1. Level. 1 runs measurement; 0 idles or aborts.
- `count` output `CNT_WIDTH`. Rising edges in the last completed gate. Holds its value until the next completed gate.
- `overflow` output 1. The last completed gate saturated `count`.
- `valid` output 1. One-cycle pulse when `count`/`overflow` update.
- `period` output `CNT_WIDTH`. Only with `FREQ_METER_PERIOD_EN`; see Configuration.
- `period_valid` output 1. Only with `FREQ_METER_PERIOD_EN`; see Configuration.

## Operation
- **Synchroniser:** `sig_in` passes through a `SYNC_STAGES` flop chain, then one history flop. Edge = synchronised high and history low. All these flops reset to 0.
- **States:** IDLE and GATE.
- **IDLE:**
  - Edges are ignored; gate and edge counters are held at 0.
  - `en`=1 moves to GATE on the next edge.
- **GATE:**
  - The gate counter runs 0..`GATE_CYCLES`-1.
  - The edge counter increments on each detected edge.
  - The edge counter saturates at 2^`CNT_WIDTH`-1 and sets an internal sticky overflow flag.
- **Gate end** (gate counter = `GATE_CYCLES`-1):
  - `count` ← edge counter + (1 if an edge occurs in this cycle, saturating).
  - `overflow` ← sticky flag, or saturation in this cycle.
  - `valid` ← 1.
  - Counters and the flag clear.
  - If `en`=1, stay in GATE: gates are contiguous, no dead cycle, and every edge lands in exactly one gate. Otherwise go to IDLE.
- **`en` falls mid-gate:** abort to IDLE next cycle. No `valid`; `count`/`overflow` keep the previous result; the partial count is discarded.
- **Input rate:** `sig_in` high and low phases must each be ≥ `SYNC_STAGES` `clk` cycles for exact counts. Faster inputs undercount and are not flagged.
- **Reset:**
  - State = IDLE.
  - `count`=0, `overflow`=0, `valid`=0, `period`=0, `period_valid`=0.
  - All counters and synchroniser flops are 0.
  - Reset mid-gate discards everything.
- **Warm-up:** because the synchroniser resets to 0, an input already high at reset produces one edge after `SYNC_STAGES`+1 cycles. That edge is ignored if `en` is still 0.

## Timing
- `sig_in` rise to edge detection: `SYNC_STAGES`+1 cycles (±1 for metastability resolution).
- `en` sampled 1 in IDLE at cycle t: the first gate cycle is t+1.
- A gate spans exactly `GATE_CYCLES` cycles. `valid` is high in the cycle after the last gate cycle, which is also the first cycle of the next gate.
- `count`, `overflow` and `valid` are registered and change together.
- At continuous `en`, successive `valid` pulses are exactly `GATE_CYCLES` cycles apart.

## Configuration
- **`FREQ_METER_PERIOD_EN` defined:** adds a period counter that runs whenever `en`=1, independent of the gate FSM.
  - It counts `clk` cycles between consecutive detected edges.
  - On each edge after the first one since `en` rose: `period` ← cycles since the previous edge, `period_valid` pulses for 1 cycle, and the counter restarts at 1.
  - The counter saturates at all-ones. `en`=0 clears the counter and disarms the block.
- **Undefined:** `period`/`period_valid` ports and all their logic are absent; the port list ends at `valid`.

## Test plan
- **Basic count:** `GATE_CYCLES`=100, `sig_in` toggles every 5 clk, `en`=1 held → `valid` every 100 cycles, `count`=10, `overflow`=0 on every gate after the first.
- **Idle input:** `sig_in`=0 constant, `en`=1 → `count`=0 each gate. Then `sig_in`=1 held → exactly one gate with `count`=1, then 0.
- **Abort:** `en` dropped at gate cycle 50 → no `valid`, `count` keeps the prior value 10. Re-raising `en` → the next `valid` comes 101 cycles later.
- **Overflow:** `CNT_WIDTH`=3, `GATE_CYCLES`=100, toggle every 3 clk → `count`=7, `overflow`=1. Then toggle every 20 clk → `count`=2 or 3, `overflow`=0.
- **Reset mid-gate:** `rst_n`=0 for 1 cycle at gate cycle 40 → all outputs 0 the next cycle, no `valid` until `en` has been held ≥ 101 cycles.
- **Period mode** (`FREQ_METER_PERIOD_EN`): toggle every 7 clk → `period`=14 with `period_valid` on every edge from the second one onward.

Source files
------------

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronised rising edges of sig_in over GATE_CYCLES clocks.
// Optional period measurement between edges is enabled by defining FREQ_METER_PERIOD_EN.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sig_in,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 overflow,
  output logic                 valid
`ifdef FREQ_METER_PERIOD_EN
  ,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid
`endif
);

  localparam int GW =
    (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST =
    GW'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE,
    GATE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   rise;

  state_t                 state_q;
  state_t                 state_d;
  logic                   gate_end;

  logic [GW-1:0]          gate_q;
  logic [GW-1:0]          gate_d;
  logic [CNT_WIDTH-1:0]   ecnt_q;
  logic [CNT_WIDTH-1:0]   ecnt_d;
  logic                   sticky_q;
  logic                   sticky_d;

  logic                   ecnt_sat;
  logic                   ecnt_inc;
  logic                   ovf_hit;
  logic [CNT_WIDTH-1:0]   ecnt_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

  assign ecnt_sat  = (ecnt_q == CNT_MAX);
  assign ecnt_inc  = rise & ~ecnt_sat;
  assign ovf_hit   = rise & ecnt_sat;
  assign ecnt_next = ecnt_q + CNT_WIDTH'(ecnt_inc);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Gate end wins over a simultaneous en drop, so a
  // fully elapsed gate is always published.
  always_comb begin
    state_d  = state_q;
    gate_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) state_d = GATE;
      end
      GATE: begin
        if (gate_q == GATE_LAST) begin
          gate_end = 1'b1;
          if (!en) state_d = IDLE;
        end else if (!en) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gate_d   = '0;
    ecnt_d   = '0;
    sticky_d = 1'b0;
    if (state_q == GATE && en && !gate_end) begin
      gate_d   = gate_q + GW'(1);
      ecnt_d   = ecnt_next;
      sticky_d = sticky_q | ovf_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_q   <= '0;
      ecnt_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      gate_q   <= gate_d;
      ecnt_q   <= ecnt_d;
      sticky_q <= sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= gate_end;
      if (gate_end) begin
        count    <= ecnt_next;
        overflow <= sticky_q | ovf_hit;
      end
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_WIDTH-1:0] pcnt_q;
  logic                 armed_q;

  // First edge after en rises only arms; later edges
  // publish the gap and restart the count at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q       <= '0;
      armed_q      <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else if (!en) begin
      pcnt_q       <= '0;
      armed_q      <= 1'b0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= rise & armed_q;
      if (rise) begin
        if (armed_q) period <= pcnt_q;
        pcnt_q  <= CNT_WIDTH'(1);
        armed_q <= 1'b1;
      end else if (pcnt_q != CNT_MAX) begin
        pcnt_q <= pcnt_q + CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: directed phases plus random toggling,
// compared each cycle against an edge-counting gate model.
module tb_freq_meter;

  localparam int G    = 100;
  localparam int W    = 4;
  localparam int S    = 2;
  localparam int CMAX = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sig_in = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] count;
  logic         overflow;
  logic         valid;
`ifdef FREQ_METER_PERIOD_EN
  logic [W-1:0] period;
  logic         period_valid;
`endif

  freq_meter #(
    .GATE_CYCLES(G),
    .CNT_WIDTH  (W),
    .SYNC_STAGES(S)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sig_in      (sig_in),
    .en          (en),
    .count       (count),
    .overflow    (overflow),
    .valid       (valid)
`ifdef FREQ_METER_PERIOD_EN
    ,
    .period      (period),
    .period_valid(period_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  int     m_count = 0;
  int     m_ovf = 0;
  int     m_valid = 0;
  bit     m_gating = 0;
  int     m_pos = 0;
  int     m_edges = 0;
  bit     dl[0:S];
  int     m_period = 0;
  int     m_pv = 0;
  bit     m_armed = 0;
  longint m_cyc = 0;
  longint m_last = 0;

  bit     cur_sig = 0;
  int     ph = 0;
  logic   obs_valid;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit e, input bit s, input bit r);
    bit rs;
    m_cyc++;
    if (!r) begin
      m_count = 0; m_ovf = 0; m_valid = 0;
      m_gating = 0; m_pos = 0; m_edges = 0;
      m_period = 0; m_pv = 0; m_armed = 0;
      for (int k = 0; k <= S; k++) dl[k] = 0;
      return;
    end
    rs = dl[S-1] && !dl[S];
    m_valid = 0;
    if (m_gating) begin
      if (rs) m_edges++;
      if (m_pos == G - 1) begin
        m_count = (m_edges > CMAX) ? CMAX : m_edges;
        m_ovf   = (m_edges > CMAX) ? 1 : 0;
        m_valid = 1;
        m_edges = 0;
        m_pos   = 0;
        m_gating = e;
      end else if (!e) begin
        m_gating = 0; m_edges = 0; m_pos = 0;
      end else begin
        m_pos++;
      end
    end else if (e) begin
      m_gating = 1; m_pos = 0; m_edges = 0;
    end
    m_pv = 0;
    if (!e) begin
      m_armed = 0;
    end else if (rs) begin
      if (m_armed) begin
        m_period = (m_cyc - m_last > CMAX) ?
                   CMAX : int'(m_cyc - m_last);
        m_pv = 1;
      end
      m_last  = m_cyc;
      m_armed = 1;
    end
    for (int k = S; k > 0; k--) dl[k] = dl[k-1];
    dl[0] = s;
  endtask

  task automatic step(input bit e, input bit s, input bit r);
    @(negedge clk);
    obs_valid = valid;
    chk("valid", {31'd0, valid}, m_valid);
    chk("count", {28'd0, count}, m_count);
    chk("overflow", {31'd0, overflow}, m_ovf);
`ifdef FREQ_METER_PERIOD_EN
    chk("period_valid", {31'd0, period_valid}, m_pv);
    chk("period", {28'd0, period}, m_period);
`endif
    en = e;
    sig_in = s;
    rst_n = r;
    model(e, s, r);
  endtask

  task automatic tog(input int half, input int n, input bit e);
    repeat (n) begin
      step(e, cur_sig, 1'b1);
      ph++;
      if (ph >= half) begin
        ph = 0;
        cur_sig = !cur_sig;
      end
    end
  endtask

  task automatic hold(input bit s, input int n, input bit e);
    cur_sig = s;
    ph = 0;
    repeat (n) step(e, s, 1'b1);
  endtask

  initial begin
    int j;
    int guard;
    for (int k = 0; k <= S; k++) dl[k] = 0;

    repeat (3) step(1'b0, 1'b0, 1'b0);
    chk("reset_count", {28'd0, count}, 0);

    tog(5, 450, 1'b1);
    chk("basic_count", {28'd0, count}, 10);
    chk("basic_ovf", {31'd0, overflow}, 0);

    guard = 0;
    while (m_pos != 50 && guard < 300) begin
      tog(5, 1, 1'b1);
      guard++;
    end
    tog(5, 30, 1'b0);
    chk("abort_keep", {28'd0, count}, 10);
    tog(5, 1, 1'b1);
    j = 0;
    for (int i = 1; i <= 150; i++) begin
      tog(5, 1, 1'b1);
      if (obs_valid === 1'b1) begin
        j = i;
        break;
      end
    end
    chk("reraise_latency", j, 101);

    hold(1'b0, 250, 1'b1);
    chk("idle_zero", {28'd0, count}, 0);
    hold(1'b1, 350, 1'b1);
    chk("held_high", {28'd0, count}, 0);

    tog(2, 350, 1'b1);
    chk("ovf_count", {28'd0, count}, CMAX);
    chk("ovf_flag", {31'd0, overflow}, 1);
    tog(20, 350, 1'b1);
    n_vec++;
    assert (count === 4'd2 || count === 4'd3) else begin
      n_err++;
      $error("FAIL slow_count: got %0d, want 2 or 3", count);
    end
    chk("slow_ovf", {31'd0, overflow}, 0);

    guard = 0;
    while (m_pos != 40 && guard < 300) begin
      tog(5, 1, 1'b1);
      guard++;
    end
    step(1'b1, cur_sig, 1'b0);
    tog(5, 1, 1'b1);
    chk("rst_count", {28'd0, count}, 0);
    chk("rst_valid", {31'd0, valid}, 0);
    j = 0;
    for (int i = 1; i <= 200; i++) begin
      tog(5, 1, 1'b1);
      if (obs_valid === 1'b1) begin
        j = i;
        break;
      end
    end
    chk("rst_latency", j, 101);

    tog(7, 300, 1'b1);
`ifdef FREQ_METER_PERIOD_EN
    chk("period_14", {28'd0, period}, 14);
`endif

    repeat (40) begin
      int half;
      int len;
      bit e;
      half = $urandom_range(2, 12);
      len  = $urandom_range(20, 200);
      e    = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0)
        step(e, cur_sig, 1'b0);
      tog(half, len, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
